// File: rtl/reg_pipeline.sv
// Stallable, clearable WIDTH x DEPTH delay line with per-stage valid,
// occupancy count, full/empty flags and a combinational tap of any stage.
`timescale 1ns/1ps
module reg_pipeline #(
  parameter  int unsigned      WIDTH     = 8,
  parameter  int unsigned      DEPTH     = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned      TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_CW  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CW:0]      count_sum;
  logic [CW-1:0]    count_nxt;

  // Occupancy is evaluated one bit wider so entry/exit can never wrap;
  // result is clamped to the legal range 0..DEPTH.
  always_comb begin
    count_sum = {1'b0, count} + (CW + 1)'(in_valid) - (CW + 1)'(vld[DEPTH-1]);
    count_nxt = count_sum[CW-1:0];
    if (!in_valid && vld[DEPTH-1] && (count == '0)) begin
      count_nxt = '0;
    end else if (count_sum > DEPTH_EXT) begin
      count_nxt = DEPTH_CW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
      vld   <= '0;
      count <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
      vld   <= '0;
      count <= '0;
    end else if (en) begin
      data[0] <= in_valid ? d : RESET_VAL;
      vld[0]  <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
      count <= count_nxt;
    end
  end

  // Out-of-range selects fall through to the bubble value, never X.
  always_comb begin
    tap_q     = RESET_VAL;
    tap_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_sel == i[TW-1:0]) begin
        tap_q     = data[i];
        tap_valid = vld[i];
      end
    end
  end

  assign q       = data[DEPTH-1];
  assign q_valid = vld[DEPTH-1];
  assign full    = (count == DEPTH_CW);
  assign empty   = (count == '0);

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed bench for reg_pipeline (WIDTH=8, DEPTH=4, RESET_VAL=0):
// reset, latency, stall, steady state, clear, tap sweep, async reset.
`timescale 1ns/1ps
module tb_reg_pipeline;

  logic       clk = 1'b0;
  logic       rst, en, clr, in_valid;
  logic [7:0] d, q, tap_q;
  logic [1:0] tap_sel;
  logic       q_valid, tap_valid, full, empty;
  logic [2:0] count;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] tap_exp [4];

  reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .d(d),
    .tap_sel(tap_sel), .q(q), .q_valid(q_valid), .tap_q(tap_q),
    .tap_valid(tap_valid), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eq, input logic eqv,
                         input logic [2:0] ecnt);
    chk({tag, ".q"},       32'(q),       32'(eq));
    chk({tag, ".q_valid"}, 32'(q_valid), 32'(eqv));
    chk({tag, ".count"},   32'(count),   32'(ecnt));
    chk({tag, ".full"},    32'(full),    32'(ecnt == 3'd4));
    chk({tag, ".empty"},   32'(empty),   32'(ecnt == 3'd0));
  endtask

  task automatic chk_tap(input string tag, input logic [1:0] sel,
                         input logic [7:0] eq, input logic ev);
    tap_sel = sel;
    #1;
    chk({tag, ".tap_q"},     32'(tap_q),     32'(eq));
    chk({tag, ".tap_valid"}, 32'(tap_valid), 32'(ev));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [7:0] data);
    in_valid = v;
    d        = data;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with live input
    rst = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b1; d = 8'hFF; tap_sel = 2'd0;
    #1;
    chk_out("rst0", 8'h00, 1'b0, 3'd0);
    tick(); chk_out("rst1", 8'h00, 1'b0, 3'd0);
    tick(); chk_out("rst2", 8'h00, 1'b0, 3'd0);
    rst = 1'b1;

    // 2. latency DEPTH with continuous enable
    push(1'b1, 8'hA1); chk_out("lat1", 8'h00, 1'b0, 3'd1);
    push(1'b1, 8'hA2); chk_out("lat2", 8'h00, 1'b0, 3'd2);
    push(1'b1, 8'hA3); chk_out("lat3", 8'h00, 1'b0, 3'd3);
    push(1'b1, 8'hA4); chk_out("lat4", 8'hA1, 1'b1, 3'd4);
    push(1'b0, 8'h00); chk_out("lat5", 8'hA2, 1'b1, 3'd3);
    push(1'b0, 8'h00); chk_out("lat6", 8'hA3, 1'b1, 3'd2);
    push(1'b0, 8'h00); chk_out("lat7", 8'hA4, 1'b1, 3'd1);
    push(1'b0, 8'h00); chk_out("lat8", 8'h00, 1'b0, 3'd0);

    // 3. stall holds everything, 0x99 never enters
    push(1'b1, 8'h11);
    push(1'b1, 8'h22);
    push(1'b1, 8'h33); chk_out("fill3", 8'h00, 1'b0, 3'd3);
    en = 1'b0;
    push(1'b1, 8'h99); chk_out("stall1", 8'h00, 1'b0, 3'd3);
    push(1'b1, 8'h99); chk_out("stall2", 8'h00, 1'b0, 3'd3);
    push(1'b1, 8'h99); chk_out("stall3", 8'h00, 1'b0, 3'd3);
    chk_tap("stall.s0", 2'd0, 8'h33, 1'b1);
    chk_tap("stall.s2", 2'd2, 8'h11, 1'b1);
    en = 1'b1;
    push(1'b0, 8'h00); chk_out("unstall", 8'h11, 1'b1, 3'd3);
    chk_tap("unstall.s0", 2'd0, 8'h00, 1'b0);
    chk_tap("unstall.s1", 2'd1, 8'h33, 1'b1);

    // 4. steady state, then a single bubble
    push(1'b1, 8'hB0); chk_out("ss0", 8'h22, 1'b1, 3'd3);
    push(1'b1, 8'hB1); chk_out("ss1", 8'h33, 1'b1, 3'd3);
    push(1'b1, 8'hB2); chk_out("ss2", 8'h00, 1'b0, 3'd3);
    push(1'b1, 8'hB3); chk_out("ss3", 8'hB0, 1'b1, 3'd4);
    push(1'b1, 8'hB4); chk_out("ss4", 8'hB1, 1'b1, 3'd4);
    push(1'b1, 8'hB5); chk_out("ss5", 8'hB2, 1'b1, 3'd4);
    push(1'b0, 8'hFF); chk_out("bub0", 8'hB3, 1'b1, 3'd3);
    push(1'b1, 8'hB6); chk_out("bub1", 8'hB4, 1'b1, 3'd3);
    push(1'b1, 8'hB7); chk_out("bub2", 8'hB5, 1'b1, 3'd3);
    push(1'b1, 8'hB8); chk_out("bub3", 8'h00, 1'b0, 3'd3);
    push(1'b1, 8'hB9); chk_out("bub4", 8'hB6, 1'b1, 3'd4);

    // 5. clear beats enable and discards the input
    clr = 1'b1;
    push(1'b1, 8'h5A); chk_out("clr", 8'h00, 1'b0, 3'd0);
    chk_tap("clr.s0", 2'd0, 8'h00, 1'b0);
    chk_tap("clr.s1", 2'd1, 8'h00, 1'b0);
    chk_tap("clr.s3", 2'd3, 8'h00, 1'b0);
    clr = 1'b0;
    push(1'b0, 8'h00); chk_out("postclr", 8'h00, 1'b0, 3'd0);

    // 6. tap sweep
    push(1'b1, 8'hA1);
    push(1'b1, 8'hA2);
    push(1'b1, 8'hA3);
    push(1'b1, 8'hA4);
    en = 1'b0;
    tap_exp[0] = 8'hA4; tap_exp[1] = 8'hA3; tap_exp[2] = 8'hA2; tap_exp[3] = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      chk_tap($sformatf("tap%0d", i), 2'(i), tap_exp[i], 1'b1);
    end
    chk_out("tapfull", 8'hA1, 1'b1, 3'd4);

    // 7. async reset between edges
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_out("arst", 8'h00, 1'b0, 3'd0);
    chk_tap("arst.s0", 2'd0, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    en  = 1'b1;
    push(1'b1, 8'hC1); chk_out("rel1", 8'h00, 1'b0, 3'd1);
    chk_tap("rel1.s0", 2'd0, 8'hC1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_pipeline.md
Name: reg_pipeline

Overview:
Parametrised multi-stage register pipeline that generalises the single D flip-flop. It provides a WIDTH-bit, DEPTH-stage delay line with per-stage valid tracking, a global stall (enable), a synchronous clear and a selectable tap. An occupancy count with full/empty flags is included. It sits between datapath blocks wherever a fixed, stallable latency with qualified data is needed.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of stages, which equals latency in enabled cycles (>=1).
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset, on clear and for bubbles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- en  input  1  advance enable; 0 = stall (all stages hold).
- clr  input  1  synchronous clear; has priority over en.
- in_valid  input  1  qualifies d this cycle.
- d  input  WIDTH  input data.
- tap_sel  input  TW  stage index for the tap output; TW = max(1, $clog2(DEPTH)).
- q  output  WIDTH  data of stage DEPTH-1 (registered).
- q_valid  output  1  valid of stage DEPTH-1.
- tap_q  output  WIDTH  data of stage tap_sel (combinational mux of registers).
- tap_valid  output  1  valid of stage tap_sel.
- count  output  CW  number of valid stages, registered; CW = $clog2(DEPTH+1).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: data[0..DEPTH-1] (WIDTH each) and vld[0..DEPTH-1].
- Reset (rst=0, asynchronous, independent of clk): all data = RESET_VAL, all vld = 0, count = 0. Outputs while in reset: q = RESET_VAL, q_valid = 0, count = 0, full = 0, empty = 1.
- Priority at each rising edge (rst=1): clr > en > hold.
- clr=1: all data = RESET_VAL, all vld = 0, count = 0. The input in that cycle is discarded, regardless of en or in_valid.
- en=1, clr=0 (shift):
  - vld[0] <= in_valid.
  - data[0] <= in_valid ? d : RESET_VAL, so bubbles carry RESET_VAL.
  - For i >= 1: data[i] <= data[i-1] and vld[i] <= vld[i-1].
  - The contents of stage DEPTH-1 are dropped.
- en=0, clr=0: every register holds its value, and count holds.
- Latency: an item accepted at edge k (en=1, in_valid=1) appears on q with q_valid=1 after the (DEPTH)th enabled edge, counting edge k. With continuous en this is DEPTH cycles. Stalled cycles do not count.
- count on a shift: count <= count + in_valid - vld[DEPTH-1]. It is computed in CW+1 bits and can never exceed DEPTH or go below 0. Simultaneous entry and exit leaves count unchanged.
- full and empty are decoded combinationally from registered count.
- Tap: tap_q = data[tap_sel] and tap_valid = vld[tap_sel]. If tap_sel >= DEPTH, tap_q = RESET_VAL and tap_valid = 0. There is no X propagation.
- DEPTH=1: the block degenerates to a single register with valid. tap_sel is 1 bit; value 1 is out of range.
- Reset asserted mid-stream clears immediately and asynchronously. On release, the first edge with en=1 behaves as a normal shift.
- No combinational path from d or in_valid to any output. The only combinational path is tap_sel to tap_q/tap_valid.

Test Plan (WIDTH=8, DEPTH=4, RESET_VAL=8'h00):
1. Reset: hold rst=0 for 2 cycles with d=8'hFF and in_valid=1, then release. Required: q=8'h00, q_valid=0, count=0, empty=1, full=0 throughout reset.
2. Latency: with en=1, send in_valid=1 and d=8'hA1, A2, A3, A4 on consecutive edges, then in_valid=0.
   - Required: q=A1 with q_valid=1 after the 4th edge, then A2, A3, A4.
   - count goes 1,2,3,4 (full=1), then 4→3→2→1→0 as bubbles enter.
3. Stall: fill with 11, 22, 33, then en=0 for 3 cycles with in_valid=1 and d=8'h99. Required: all stages, count=3 and q hold; 8'h99 is never captured. After en returns to 1, 11 appears on q after one more shift (4th enabled edge from its entry).
4. Steady state: with full pipeline and continuous in_valid=1, count stays at 4 while q streams. Then insert one in_valid=0 cycle. Required: q=8'h00 with q_valid=0 exactly 4 cycles later, and count dips to 3.
5. Clear priority: with the pipe holding 4 items, assert clr=1 together with en=1, in_valid=1 and d=8'h5A. Required: after that edge all vld=0, count=0, empty=1, q=8'h00, and 5A is not stored.
6. Tap: after loading A1..A4 (A4 in stage 0), sweep tap_sel through 0,1,2,3. Required: tap_q = A4, A3, A2, A1 with tap_valid=1.
7. Async reset mid-stream: assert rst=0 between clock edges while the pipe is full. Required: q, q_valid and count go to 0 before the next edge.
